// File: rtl/riscv_seq_ctrl_if.sv
// Memory bus between the sequencer and instruction/data memory.
// master (sequencer): drives mem_req, mem_we, mem_is_fetch; samples mem_ready.
// slave  (memory)   : samples the request; drives mem_ready.
// The access address is the sequencer's o_pc.
interface riscv_seq_ctrl_if;
    logic mem_req;       // access request
    logic mem_we;        // store (valid with mem_req)
    logic mem_is_fetch;  // request is an instruction fetch
    logic mem_ready;     // memory completes the access this cycle

    modport master (output mem_req, output mem_we, output mem_is_fetch, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_is_fetch, output mem_ready);
endinterface

// File: rtl/riscv_seq_ctrl.sv
// Multi-cycle RV32I sequencer: owns the PC, walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, resolves next-PC, halts on system/faults and
// counts retired instructions.
// Ports:
//   clk, rst_n       clock (rising), async active-low reset
//   i_run            allow a new fetch to start
//   i_opcode         IR opcode field
//   i_branch_taken   comparator result for current branch
//   i_target         branch/jump target from datapath
//   mem              memory bus (master side)
//   o_pc             current instruction address
//   o_ir_load        latch instruction word into IR
//   o_reg_write      register file write strobe
//   o_retire         1-cycle pulse per completed instruction
//   o_instret        retired-instruction count
//   o_state          FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5
//   o_halted         state==HALT
//   o_fault          0 none/system, 1 illegal, 2 misaligned, 3 mem timeout
module riscv_seq_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 32,
    parameter int          TIMEOUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_run,
    input  logic [6:0]           i_opcode,
    input  logic                 i_branch_taken,
    input  logic [31:0]          i_target,
    riscv_seq_ctrl_if.master     mem,
    output logic [31:0]          o_pc,
    output logic                 o_ir_load,
    output logic                 o_reg_write,
    output logic                 o_retire,
    output logic [CNT_W-1:0]     o_instret,
    output logic [2:0]           o_state,
    output logic                 o_halted,
    output logic [1:0]           o_fault
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5
    } state_t;

    state_t               r_state;
    logic [31:0]          r_pc;
    logic [CNT_W-1:0]     r_instret;
    logic [1:0]           r_fault;
    logic [TIMEOUT_W-1:0] r_tmo;

    logic w_load, w_store, w_branch, w_jal, w_jalr, w_fence, w_system, w_legal;
    logic w_fire, w_stall, w_tmo_hit, w_br_misal, w_wb_misal;
    logic [31:0]          w_pc4, w_wb_next;
    logic [TIMEOUT_W-1:0] w_tmo_inc;

    assign w_load   = (i_opcode == 7'b0000011);
    assign w_store  = (i_opcode == 7'b0100011);
    assign w_branch = (i_opcode == 7'b1100011);
    assign w_jal    = (i_opcode == 7'b1101111);
    assign w_jalr   = (i_opcode == 7'b1100111);
    assign w_fence  = (i_opcode == 7'b0001111);
    assign w_system = (i_opcode == 7'b1110011);
    assign w_legal  = w_load | w_store | w_branch | w_jal | w_jalr | w_fence | w_system |
                      (i_opcode == 7'b0110011) | (i_opcode == 7'b0010011) |
                      (i_opcode == 7'b0110111) | (i_opcode == 7'b0010111);

    // Strobes are gated by rst_n so nothing leaks out while reset is held.
    assign mem.mem_req      = rst_n & (((r_state == S_FETCH) & i_run) | (r_state == S_MEM));
    assign mem.mem_we       = rst_n & (r_state == S_MEM) & w_store;
    assign mem.mem_is_fetch = (r_state == S_FETCH);

    assign w_fire    = mem.mem_req & mem.mem_ready;
    assign w_stall   = mem.mem_req & ~mem.mem_ready;
    assign w_tmo_inc = r_tmo + 1'b1;
    assign w_tmo_hit = (w_tmo_inc == {TIMEOUT_W{1'b1}});

    assign w_pc4      = r_pc + 32'd4;
    // jalr clears bit0; misalignment is judged on bit1 of the resulting PC.
    assign w_wb_next  = w_jal ? i_target : w_jalr ? {i_target[31:1], 1'b0} : w_pc4;
    assign w_br_misal = w_branch & i_branch_taken & i_target[1];
    assign w_wb_misal = (w_jal | w_jalr) & i_target[1];

    assign o_ir_load   = rst_n & (r_state == S_FETCH) & w_fire;
    assign o_reg_write = rst_n & (r_state == S_WB) & ~w_wb_misal;
    assign o_retire    = rst_n & (((r_state == S_EXEC) & (w_fence | (w_branch & ~w_br_misal))) |
                                  ((r_state == S_MEM) & w_fire & w_store) |
                                  ((r_state == S_WB) & ~w_wb_misal));

    assign o_pc      = r_pc;
    assign o_instret = r_instret;
    assign o_state   = r_state;
    assign o_halted  = (r_state == S_HALT);
    assign o_fault   = r_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_instret <= '0;
            r_fault   <= 2'd0;
            r_tmo     <= '0;
        end else begin
            if (o_retire) r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
            case (r_state)
                S_FETCH: begin
                    if (w_fire) r_state <= S_DECODE;
                    else if (w_stall) begin
                        // A ready in the limit cycle completes instead of timing out.
                        if (w_tmo_hit) begin r_state <= S_HALT; r_fault <= 2'd3; end
                        else r_tmo <= w_tmo_inc;
                    end
                end
                S_DECODE: begin
                    if (!w_legal)     begin r_state <= S_HALT; r_fault <= 2'd1; end
                    else if (w_system) r_state <= S_HALT;
                    else               r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_load | w_store) begin
                        r_state <= S_MEM;
                        r_tmo   <= '0;
                    end else if (w_branch) begin
                        if (w_br_misal) begin r_state <= S_HALT; r_fault <= 2'd2; end
                        else begin
                            r_pc    <= i_branch_taken ? i_target : w_pc4;
                            r_state <= S_FETCH;
                            r_tmo   <= '0;
                        end
                    end else if (w_fence) begin
                        r_pc    <= w_pc4;
                        r_state <= S_FETCH;
                        r_tmo   <= '0;
                    end else r_state <= S_WB;
                end
                S_MEM: begin
                    if (w_fire) begin
                        if (w_store) begin
                            r_pc    <= w_pc4;
                            r_state <= S_FETCH;
                            r_tmo   <= '0;
                        end else r_state <= S_WB;
                    end else if (w_stall) begin
                        if (w_tmo_hit) begin r_state <= S_HALT; r_fault <= 2'd3; end
                        else r_tmo <= w_tmo_inc;
                    end
                end
                S_WB: begin
                    if (w_wb_misal) begin r_state <= S_HALT; r_fault <= 2'd2; end
                    else begin
                        r_pc    <= w_wb_next;
                        r_state <= S_FETCH;
                        r_tmo   <= '0;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_HALT;
            endcase
        end
    end
endmodule
